// File: rtl/temp_zone_monitor.sv
// temp_zone_monitor: converts a left-justified two's-complement sensor word
// into sign + BCD hundreds/tens/units/tenths, and classifies it into
// COLD/NORMAL/HOT zones with hysteresis and a persistence filter.
// Optional feature macro: TEMP_MINMAX_EN adds clr_minmax, t_min and t_max.
//
// Handshake: sample_valid is a one-cycle strobe with no back-pressure. It is
// accepted only while busy is low (IDLE). A strobe while busy is dropped and
// sets the sticky overrun flag. out_valid pulses for one cycle when every
// result output (sign, digits, lcd_sel, zone_chg) carries the new sample.
module temp_zone_monitor #(
  parameter int FRAC_BITS = 1,
  parameter int HYST      = 1,
  parameter int PERSIST   = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [15:0]                   data,
  input  logic                          sample_valid,
  input  logic signed [8+FRAC_BITS-1:0] thr_lo,
  input  logic signed [8+FRAC_BITS-1:0] thr_hi,
`ifdef TEMP_MINMAX_EN
  input  logic                          clr_minmax,
  output logic signed [8+FRAC_BITS-1:0] t_min,
  output logic signed [8+FRAC_BITS-1:0] t_max,
`endif
  output logic                          busy,
  output logic                          out_valid,
  output logic                          sign,
  output logic [3:0]                    hundreds,
  output logic [3:0]                    dezena,
  output logic [3:0]                    unidade,
  output logic [3:0]                    lsb,
  output logic [1:0]                    lcd_sel,
  output logic                          zone_chg,
  output logic                          overrun,
  output logic [1:0]                    dbg_state
);

  localparam int TW = 8 + FRAC_BITS;
  localparam logic [1:0] Z_COLD = 2'd0;
  localparam logic [1:0] Z_NORM = 2'd1;
  localparam logic [1:0] Z_HOT  = 2'd2;
  localparam logic signed [TW:0] HYST_X = (TW+1)'(HYST);
  localparam logic [3:0] PERSIST_C = 4'(PERSIST);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CONV  = 2'd1,
    S_CLASS = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            conv_cnt_q, conv_cnt_d;
  logic signed [TW-1:0]  t_q, t_d, lo_q, lo_d, hi_q, hi_d;
  logic [19:0]           sh_q, sh_d;  // {BCD[11:0], integer magnitude[7:0]}
  logic                  busy_q, busy_d, out_valid_q, out_valid_d;
  logic                  zone_chg_q, zone_chg_d, overrun_q, overrun_d;
  logic                  sign_q, sign_d, init_q, init_d;
  logic [3:0]            hundreds_q, hundreds_d, dezena_q, dezena_d;
  logic [3:0]            unidade_q, unidade_d, lsb_q, lsb_d;
  logic [1:0]            zone_q, zone_d, prev_q, prev_d, cand;
  logic [3:0]            pcnt_q, pcnt_d, cnt_next;

  logic signed [TW-1:0]  t_in;
  logic [TW-1:0]         mag_in, mag;
  logic signed [TW:0]    t_x, lo_x, hi_x, lo_p, hi_m;
  logic [7:0]            frac_x;
  logic                  unused_bits;

  // One double-dabble step: add 3 to any BCD digit >= 5, then shift left.
  function automatic logic [19:0] dd_step(input logic [19:0] s);
    logic [19:0] a;
    a = s;
    for (int i = 0; i < 3; i++) begin
      if (a[8+4*i +: 4] >= 4'd5) a[8+4*i +: 4] = a[8+4*i +: 4] + 4'd3;
    end
    return {a[18:0], 1'b0};
  endfunction

  assign t_in   = data[15 -: TW];
  assign mag_in = t_in[TW-1] ? -t_in : t_in;
  assign mag    = t_q[TW-1] ? -t_q : t_q;
  assign frac_x = 8'(mag[FRAC_BITS-1:0]);
  assign unused_bits = ^{data[15-TW:0], mag_in[FRAC_BITS-1:0], mag[TW-1:FRAC_BITS]};

  // Candidate zone from current zone and captured T; threshold +/- HYST in TW+1 bits.
  always_comb begin
    t_x  = (TW+1)'(t_q);
    lo_x = (TW+1)'(lo_q);
    hi_x = (TW+1)'(hi_q);
    lo_p = lo_x + HYST_X;
    hi_m = hi_x - HYST_X;
    cand = Z_NORM;
    case (zone_q)
      Z_COLD: begin
        if (t_x >= hi_x)      cand = Z_HOT;
        else if (t_x > lo_p)  cand = Z_NORM;
        else                  cand = Z_COLD;
      end
      Z_HOT: begin
        // With inverted thresholds an overlap region exists; HOT wins there.
        if ((t_x <= lo_x) && !((lo_x >= hi_x) && (t_x >= hi_x))) cand = Z_COLD;
        else if (t_x < hi_m)  cand = Z_NORM;
        else                  cand = Z_HOT;
      end
      default: begin
        if (t_x >= hi_x)      cand = Z_HOT;
        else if (t_x <= lo_x) cand = Z_COLD;
        else                  cand = Z_NORM;
      end
    endcase
  end

  // Next-state logic: capture, 8-cycle conversion, classification, result pulse.
  always_comb begin
    state_d     = state_q;
    conv_cnt_d  = conv_cnt_q;
    t_d         = t_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    sh_d        = sh_q;
    busy_d      = busy_q;
    out_valid_d = 1'b0;
    zone_chg_d  = 1'b0;
    overrun_d   = overrun_q;
    sign_d      = sign_q;
    hundreds_d  = hundreds_q;
    dezena_d    = dezena_q;
    unidade_d   = unidade_q;
    lsb_d       = lsb_q;
    zone_d      = zone_q;
    prev_d      = prev_q;
    pcnt_d      = pcnt_q;
    init_d      = init_q;
    cnt_next    = pcnt_q;
    case (state_q)
      S_IDLE: begin
        if (sample_valid) begin
          t_d        = t_in;
          lo_d       = thr_lo;
          hi_d       = thr_hi;
          sh_d       = {12'd0, mag_in[TW-1 -: 8]};
          conv_cnt_d = 3'd0;
          busy_d     = 1'b1;
          state_d    = S_CONV;
        end
      end
      S_CONV: begin
        sh_d       = dd_step(sh_q);
        conv_cnt_d = conv_cnt_q + 3'd1;
        if (conv_cnt_q == 3'd7) state_d = S_CLASS;
      end
      S_CLASS: begin
        state_d     = S_DONE;
        out_valid_d = 1'b1;
        sign_d      = t_q[TW-1] & (t_q != '0);
        hundreds_d  = sh_q[19:16];
        dezena_d    = sh_q[15:12];
        unidade_d   = sh_q[11:8];
        lsb_d       = 4'((frac_x * 8'd10) >> FRAC_BITS);
        if (init_q) begin
          zone_d = cand;
          prev_d = cand;
          pcnt_d = 4'd0;
          init_d = 1'b0;
        end else begin
          prev_d = cand;
          if (cand == zone_q)      cnt_next = 4'd0;
          else if (cand != prev_q) cnt_next = 4'd1;
          else                     cnt_next = pcnt_q + 4'd1;
          if (cnt_next == PERSIST_C) begin
            zone_d     = cand;
            pcnt_d     = 4'd0;
            zone_chg_d = 1'b1;
          end else begin
            pcnt_d = cnt_next;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
    if (sample_valid && (state_q != S_IDLE)) overrun_d = 1'b1;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      conv_cnt_q  <= 3'd0;
      t_q         <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      sh_q        <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      zone_chg_q  <= 1'b0;
      overrun_q   <= 1'b0;
      sign_q      <= 1'b0;
      hundreds_q  <= 4'd0;
      dezena_q    <= 4'd0;
      unidade_q   <= 4'd0;
      lsb_q       <= 4'd0;
      zone_q      <= Z_NORM;
      prev_q      <= Z_NORM;
      pcnt_q      <= 4'd0;
      init_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      conv_cnt_q  <= conv_cnt_d;
      t_q         <= t_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      sh_q        <= sh_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      zone_chg_q  <= zone_chg_d;
      overrun_q   <= overrun_d;
      sign_q      <= sign_d;
      hundreds_q  <= hundreds_d;
      dezena_q    <= dezena_d;
      unidade_q   <= unidade_d;
      lsb_q       <= lsb_d;
      zone_q      <= zone_d;
      prev_q      <= prev_d;
      pcnt_q      <= pcnt_d;
      init_q      <= init_d;
    end
  end

`ifdef TEMP_MINMAX_EN
  logic                 mm_load_q, mm_load_d;
  logic signed [TW-1:0] t_min_q, t_min_d, t_max_q, t_max_d;

  // Extremes tracker; a pending load (reset or clear) makes the next result load both.
  always_comb begin
    mm_load_d = mm_load_q | clr_minmax;
    t_min_d   = t_min_q;
    t_max_d   = t_max_q;
    if (state_q == S_DONE) begin
      mm_load_d = 1'b0;
      if (mm_load_q || clr_minmax) begin
        t_min_d = t_q;
        t_max_d = t_q;
      end else begin
        if (t_q < t_min_q) t_min_d = t_q;
        if (t_q > t_max_q) t_max_d = t_q;
      end
    end
  end

  // Extremes registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mm_load_q <= 1'b1;
      t_min_q   <= '0;
      t_max_q   <= '0;
    end else begin
      mm_load_q <= mm_load_d;
      t_min_q   <= t_min_d;
      t_max_q   <= t_max_d;
    end
  end

  assign t_min = t_min_q;
  assign t_max = t_max_q;
`endif

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign sign      = sign_q;
  assign hundreds  = hundreds_q;
  assign dezena    = dezena_q;
  assign unidade   = unidade_q;
  assign lsb       = lsb_q;
  assign lcd_sel   = zone_q;
  assign zone_chg  = zone_chg_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_temp_zone_monitor.sv
// Testbench for temp_zone_monitor (default build, FRAC_BITS=1, HYST=1, PERSIST=3).
// A behavioural model predicts each accepted sample's result from plain
// arithmetic and the zone rules; a monitor checks busy/overrun every cycle and
// every out_valid against the expected queue.
`timescale 1ns/1ps
module tb_temp_zone_monitor;
  localparam int FB      = 1;
  localparam int TW      = 8 + FB;
  localparam int HYST    = 1;
  localparam int PERSIST = 3;

  // ---------------- clock / reset / DUT ----------------
  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [15:0]          data = 16'h0;
  logic                 sample_valid = 1'b0;
  logic signed [TW-1:0] thr_lo = 9'sd64;
  logic signed [TW-1:0] thr_hi = 9'sd71;
  logic                 busy, out_valid, sign, zone_chg, overrun;
  logic [3:0]           hundreds, dezena, unidade, lsb;
  logic [1:0]           lcd_sel, dbg_state;

  temp_zone_monitor #(.FRAC_BITS(FB), .HYST(HYST), .PERSIST(PERSIST)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .sample_valid(sample_valid),
    .thr_lo(thr_lo), .thr_hi(thr_hi), .busy(busy), .out_valid(out_valid),
    .sign(sign), .hundreds(hundreds), .dezena(dezena), .unidade(unidade),
    .lsb(lsb), .lcd_sel(lcd_sel), .zone_chg(zone_chg), .overrun(overrun),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Result packing: {sign, hundreds, tens, units, tenths, zone, zone_chg}
  logic [19:0] exp_q[$];
  int          cap_q[$];
  logic [19:0] last_out = '0;
  int m_zone = 1, m_init = 1, m_cnt = 0, m_prev = 1;
  int m_cap = -100, m_next_ok = 0, m_overrun = 0;
  bit mon_on = 1'b0;

  function automatic int cand_of(input int c, input int t, input int lo, input int hi);
    if (c == 0) begin
      if (t >= hi) return 2;
      if (t > lo + HYST) return 1;
      return 0;
    end else if (c == 2) begin
      if (t <= lo && !(lo >= hi && t >= hi)) return 0;
      if (t < hi - HYST) return 1;
      return 2;
    end
    if (t >= hi) return 2;
    if (t <= lo) return 0;
    return 1;
  endfunction

  task automatic model_capture(input logic [15:0] d, input int lo, input int hi);
    logic [8:0] raw;
    int t, m, ip, fr, z, chg;
    raw = d[15:7];
    t   = int'($signed(raw));
    m   = (t < 0) ? -t : t;
    ip  = m / (1 << FB);
    fr  = m % (1 << FB);
    z   = cand_of(m_zone, t, lo, hi);
    chg = 0;
    if (m_init != 0) begin
      m_zone = z; m_prev = z; m_cnt = 0; m_init = 0;
    end else begin
      if (z == m_zone)      m_cnt = 0;
      else if (z != m_prev) m_cnt = 1;
      else                  m_cnt = m_cnt + 1;
      m_prev = z;
      if (m_cnt == PERSIST) begin
        m_zone = z; m_cnt = 0; chg = 1;
      end
    end
    exp_q.push_back({1'(t < 0), 4'(ip / 100), 4'((ip / 10) % 10), 4'(ip % 10),
                     4'((fr * 10) >> FB), 2'(m_zone), 1'(chg)});
  endtask

  // ---------------- driver tasks ----------------
  // One cycle of stimulus; the model decides whether the DUT accepts the strobe.
  task automatic drive_cycle(input logic v, input logic [15:0] d);
    data = d;
    sample_valid = v;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    if (v) begin
      if (cyc >= m_next_ok) begin
        model_capture(d, int'(thr_lo), int'(thr_hi));
        cap_q.push_back(cyc);
        m_cap = cyc;
        m_next_ok = cyc + 11;  // IDLE again 11 edges after the capture edge
      end else begin
        m_overrun = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(1'b0, data);
  endtask

  // Strobe then wait until the DUT is back in IDLE (back-to-back capable).
  task automatic send(input logic [15:0] d);
    drive_cycle(1'b1, d);
    idle(10);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sample_valid = 1'b0;
    @(posedge clk);
    #1;
    m_zone = 1; m_init = 1; m_cnt = 0; m_prev = 1;
    m_cap = -100; m_next_ok = 0; m_overrun = 0;
    exp_q.delete();
    cap_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check(tag, {sign, hundreds, dezena, unidade, lsb, lcd_sel, zone_chg, out_valid, busy, overrun},
          {1'b0, 16'h0000, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [19:0] mon_got;
  always @(posedge clk) begin
    #2;
    if (mon_on) begin
      // Busy from the cycle after the capture edge up to and including DONE.
      check("busy", busy, (cyc >= m_cap && cyc <= m_cap + 9));
      check("overrun", overrun, m_overrun[0]);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", out_valid, 1'b0);
        end else begin
          mon_got = {sign, hundreds, dezena, unidade, lsb, lcd_sel, zone_chg};
          // Visible after edge 9 past the capture edge: the 10th cycle after it.
          check("latency", cyc - cap_q.pop_front(), 9);
          check("result", mon_got, exp_q.pop_front());
          last_out = mon_got;
        end
      end else begin
        check("zone_chg_idle", zone_chg, 1'b0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  int lo, hi, t, tmin, tmax;
  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    mon_on = 1'b1;
    check_reset_values("reset_values");

    // Test 1: 25.5 degC, first sample adopts COLD immediately
    thr_lo = 9'sd64; thr_hi = 9'sd71;
    send(16'h1980);
    check("t1_result", last_out, {1'b0, 4'd0, 4'd2, 4'd5, 4'd5, 2'd0, 1'b0});

    // Test 2: hysteresis keeps COLD at 32.5, 33.0 held three times moves to NORMAL
    repeat (3) send(16'h2080);
    check("t2_cold_held", last_out[2:0], {2'd0, 1'b0});
    repeat (2) send(16'h2100);
    check("t2_not_yet", last_out[2:0], {2'd0, 1'b0});
    send(16'h2100);
    check("t2_switch", last_out[2:0], {2'd1, 1'b1});

    // Test 3: -128.0 and -0.5
    send(16'h8000);
    check("t3_min_digits", last_out[19:3], {1'b1, 4'd1, 4'd2, 4'd8, 4'd0});
    send(16'hFF80);
    check("t3_neg_half", last_out[19:3], {1'b1, 4'd0, 4'd0, 4'd0, 4'd5});

    // Test 4: strobe held through the whole conversion -> one result, sticky overrun
    repeat (11) drive_cycle(1'b1, 16'h1980);
    idle(12);
    check("t4_overrun_set", overrun, 1'b1);
    send(16'h2100);
    send(16'h1000);
    check("t4_overrun_sticky", overrun, 1'b1);
    do_reset();
    check("t4_overrun_cleared", overrun, 1'b0);

    // Test 5: reset in CONV cycle 4 aborts, next sample behaves as first
    send(16'h2100);
    drive_cycle(1'b1, 16'h2400);
    idle(3);
    do_reset();
    idle(14);
    check_reset_values("t5_abort_reset_values");
    send(16'h2400);
    check("t5_init_zone", last_out[2:0], {2'd2, 1'b0});

    // Test 6: inverted thresholds, HOT wins
    do_reset();
    thr_lo = 9'sd80; thr_hi = 9'sd70;
    send(16'h2400);
    check("t6_hot_priority", last_out[2:0], {2'd2, 1'b0});

    // Randomized phase: thresholds change every few samples, stray strobes while busy
    do_reset();
    for (int blk = 0; blk < 10; blk++) begin
      lo = int'($urandom_range(0, 140)) - 40;
      if ($urandom_range(0, 7) == 0) hi = lo - int'($urandom_range(0, 10));
      else                           hi = lo + int'($urandom_range(1, 12));
      thr_lo = TW'(lo);
      thr_hi = TW'(hi);
      tmin = ((lo < hi) ? lo : hi) - 6;
      tmax = ((lo < hi) ? hi : lo) + 6;
      for (int k = 0; k < 7; k++) begin
        if ($urandom_range(0, 9) == 0) begin
          data = 16'($urandom);
        end else begin
          t = int'($urandom_range(0, tmax - tmin)) + tmin;
          data = {9'(t), 7'($urandom_range(0, 127))};
        end
        drive_cycle(1'b1, data);
        for (int j = 0; j < 10; j++)
          drive_cycle($urandom_range(0, 19) == 0, 16'($urandom));
        idle($urandom_range(0, 2));
      end
    end

    idle(12);
    check("pending_results", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
